// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types: instruction-cycle phases, bus nibble/byte/address types
// and the fetch-source tag used by the CPU-side sequencers.
package mcs4;

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } instr_cyc_t;

    typedef logic [3:0]  char_t;
    typedef logic [7:0]  byte_t;
    typedef logic [11:0] addr_t;

    typedef enum logic {
        SRC_AUTO = 1'b0,
        SRC_HOST = 1'b1
    } fetch_src_t;

    function automatic instr_cyc_t next_phase(input instr_cyc_t ph);
        case (ph)
            A1:      return A2;
            A2:      return A3;
            A3:      return M1;
            M1:      return M2;
            M2:      return X1;
            X1:      return X2;
            X2:      return X3;
            X3:      return A1;
            default: return X3;
        endcase
    endfunction

endpackage

// File: rtl/mcs4_timing_gen.sv
// Free-running 8-phase instruction-cycle counter with the sync strobe (high in X3).
// Shared by the ROM fetch sequencer and the future RAM/IO sequencer.
module mcs4_timing_gen
    import mcs4::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    output instr_cyc_t o_ph,
    output logic       o_sync
);

    instr_cyc_t r_ph;
    logic       r_sync;
    instr_cyc_t w_ph_nxt;

    always_comb begin
        w_ph_nxt = next_phase(r_ph);
    end

    // sync is registered from the next phase so it lines up exactly with X3
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ph   <= X3;
            r_sync <= 1'b1;
        end else begin
            r_ph   <= w_ph_nxt;
            r_sync <= (w_ph_nxt == X3);
        end
    end

    assign o_ph   = r_ph;
    assign o_sync = r_sync;

endmodule

// File: rtl/mcs4_fetch_seq.sv
// CPU-side ROM bus sequencer: drives the address nibbles, captures the returned byte
// and reports it; fetch slots go to the host buffer first, else the auto PC.
module mcs4_fetch_seq
    import mcs4::*;
#(
    parameter addr_t PC_RESET = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sync,
    output logic        cm_rom,
    output char_t       dbus_out,
    input  char_t       dbus_in,
    input  logic        req_valid,
    input  logic [11:0] req_addr,
    output logic        req_ready,
    input  logic        run_en,
    input  logic        pc_load,
    input  logic [11:0] pc_load_val,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic [11:0] resp_addr,
    output logic        resp_host
);

    instr_cyc_t w_ph;
    logic       w_sync;

    mcs4_timing_gen u_timing (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_ph   (w_ph),
        .o_sync (w_sync)
    );

    logic       r_buf_valid;
    addr_t      r_buf_addr;
    addr_t      r_pc;
    logic       r_act_valid;
    addr_t      r_act_addr;
    fetch_src_t r_act_src;
    char_t      r_opr;
    char_t      r_dbus;
    logic       r_cm_rom;
    logic       r_resp_valid;
    byte_t      r_resp_data;
    addr_t      r_resp_addr;
    logic       r_resp_host;

    logic  w_accept;
    logic  w_take_buf;
    logic  w_take_pc;
    addr_t w_sel_addr;

    // Only a buffer entry already valid during X3 wins the slot; a same-edge write waits
    always_comb begin
        w_accept   = req_valid && !r_buf_valid;
        w_take_buf = (w_ph == X3) && r_buf_valid;
        w_take_pc  = (w_ph == X3) && !r_buf_valid && run_en;
        w_sel_addr = r_buf_valid ? r_buf_addr : r_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid  <= 1'b0;
            r_buf_addr   <= 12'h000;
            r_pc         <= PC_RESET;
            r_act_valid  <= 1'b0;
            r_act_addr   <= 12'h000;
            r_act_src    <= SRC_AUTO;
            r_opr        <= 4'h0;
            r_dbus       <= 4'h0;
            r_cm_rom     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 8'h00;
            r_resp_addr  <= 12'h000;
            r_resp_host  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_buf_valid <= 1'b1;
                r_buf_addr  <= req_addr;
            end else if (w_take_buf) begin
                r_buf_valid <= 1'b0;
            end else begin
                r_buf_valid <= r_buf_valid;
            end

            // pc_load wins over the increment; the already-selected fetch keeps its address
            if (pc_load) begin
                r_pc <= pc_load_val;
            end else if (w_take_pc) begin
                r_pc <= r_pc + 12'd1;
            end else begin
                r_pc <= r_pc;
            end

            if (w_ph == X3) begin
                r_act_valid <= w_take_buf || w_take_pc;
                r_act_addr  <= w_sel_addr;
                r_act_src   <= r_buf_valid ? SRC_HOST : SRC_AUTO;
            end else begin
                r_act_valid <= r_act_valid;
            end

            // Bus outputs are registered one phase ahead of the phase they belong to
            case (w_ph)
                X3: begin
                    r_dbus   <= (w_take_buf || w_take_pc) ? w_sel_addr[3:0] : 4'h0;
                    r_cm_rom <= 1'b0;
                end
                A1: begin
                    r_dbus   <= r_act_valid ? r_act_addr[7:4] : 4'h0;
                    r_cm_rom <= 1'b0;
                end
                A2: begin
                    r_dbus   <= r_act_valid ? r_act_addr[11:8] : 4'h0;
                    r_cm_rom <= r_act_valid;
                end
                default: begin
                    r_dbus   <= 4'h0;
                    r_cm_rom <= 1'b0;
                end
            endcase

            if ((w_ph == M1) && r_act_valid) begin
                r_opr <= dbus_in;
            end else begin
                r_opr <= r_opr;
            end

            if ((w_ph == M2) && r_act_valid) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= {r_opr, dbus_in};
                r_resp_addr  <= r_act_addr;
                r_resp_host  <= (r_act_src == SRC_HOST);
            end else begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign sync       = w_sync;
    assign cm_rom     = r_cm_rom;
    assign dbus_out   = r_dbus;
    assign req_ready  = !r_buf_valid;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_addr  = r_resp_addr;
    assign resp_host  = r_resp_host;

endmodule
